// File: rtl/spi_sample_tx_pkg.sv
// Shared definitions for the SPI sample transmitter: FSM encoding,
// synchroniser depth and the SPI mode the serialiser implements.
package spi_sample_tx_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_HIGH = 2'd0,
    ST_IDLE      = 2'd1,
    ST_LOAD      = 2'd2,
    ST_SHIFT     = 2'd3
  } spi_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int SPI_MODE    = 0;

  // Modes 0 and 3 both change data on the falling SCLK edge.
  localparam bit SHIFT_ON_FALL = (SPI_MODE == 0) || (SPI_MODE == 3);

  // cs_b must look high this many consecutive cycles before leaving
  // WAIT_HIGH, so the reset value of the synchroniser cannot fake a high.
  localparam int WAIT_HIGH_CYCLES = SYNC_STAGES + 1;

endpackage

// File: rtl/spi_sample_tx_fifo.sv
// Circular sample FIFO with wrapping pointers. A pop always takes effect
// before a push in the same cycle, so a full FIFO can pop and push at once.
module sample_fifo #(
  parameter int DATA_LENGTH = 10,
  parameter int FIFO_DEPTH  = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                   dest_clk,
  input  logic                   reset_b,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_LENGTH-1:0] din,
  output logic [DATA_LENGTH-1:0] dout,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count
);

  logic [DATA_LENGTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_pop_ok;
  logic                   w_push_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge dest_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

  always_ff @(posedge dest_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_sample_tx.sv
// Queues words from the CDC handshake stage and shifts them MSB-first to an
// external SPI master; SCLK and CS are oversampled by dest_clk.
module spi_sample_tx
  import spi_sample_tx_pkg::*;
#(
  parameter int DATA_LENGTH = 10,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   dest_clk,
  input  logic                   reset_b,
  input  logic                   dest_req,
  input  logic [DATA_LENGTH-1:0] Data_in,
  input  logic                   spi_sclk,
  input  logic                   spi_cs_b,
  output logic                   spi_miso,
  output logic [CNT_W-1:0]       fifo_count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   flags_clr
);

  localparam int BIT_W = $clog2(DATA_LENGTH);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   r_req_d;
  spi_state_t             r_state;
  logic [DATA_LENGTH-1:0] r_shift;
  logic [BIT_W-1:0]       r_bitcnt;
  logic [1:0]             r_wait_cnt;
  logic                   r_miso;
  logic                   r_overflow;
  logic                   r_underflow;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_sclk_fall;
  logic                   w_sclk_rise;
  logic                   w_shift_edge;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_ovf_set;
  logic                   w_unf_set;
  logic [DATA_LENGTH-1:0] w_fifo_dout;

  always_ff @(posedge dest_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b1;
      r_cs_d      <= 1'b1;
      r_req_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_b};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
      r_req_d     <= dest_req;
    end
  end

  assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_fall  = r_sclk_d & ~w_sclk_s;
  assign w_sclk_rise  = ~r_sclk_d & w_sclk_s;
  assign w_shift_edge = SHIFT_ON_FALL ? w_sclk_fall : w_sclk_rise;
  assign w_cs_fall    = r_cs_d & ~w_cs_s;
  assign w_cs_rise    = ~r_cs_d & w_cs_s;

  assign w_push    = dest_req & ~r_req_d;
  assign w_pop     = (r_state == ST_LOAD) & ~w_empty;
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_unf_set = (r_state == ST_LOAD) & w_empty;

  sample_fifo #(
    .DATA_LENGTH (DATA_LENGTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .dest_clk (dest_clk),
    .reset_b  (reset_b),
    .push     (w_push),
    .pop      (w_pop),
    .din      (Data_in),
    .dout     (w_fifo_dout),
    .full     (w_full),
    .empty    (w_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge dest_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state    <= ST_WAIT_HIGH;
      r_miso     <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_WAIT_HIGH: begin
          r_miso <= 1'b0;
          if (w_cs_s) begin
            if (r_wait_cnt == 2'(WAIT_HIGH_CYCLES - 1)) r_state <= ST_IDLE;
            else                                        r_wait_cnt <= r_wait_cnt + 2'd1;
          end else begin
            r_wait_cnt <= '0;
          end
        end
        ST_IDLE: begin
          r_miso     <= 1'b0;
          r_wait_cnt <= '0;
          if (w_cs_fall) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_shift  <= w_empty ? '0 : w_fifo_dout;
          r_bitcnt <= BIT_W'(DATA_LENGTH - 1);
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_miso  <= ~w_empty & w_fifo_dout[DATA_LENGTH-1];
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_miso  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_shift_edge) begin
            // Once the counter bottoms out, extra clocks only shift zeros.
            r_shift  <= {r_shift[DATA_LENGTH-2:0], 1'b0};
            r_miso   <= (r_bitcnt != '0) & r_shift[DATA_LENGTH-2];
            r_bitcnt <= (r_bitcnt == '0) ? '0 : r_bitcnt - BIT_W'(1);
          end
        end
        default: r_state <= ST_WAIT_HIGH;
      endcase
    end
  end

  // A set event in the same cycle as flags_clr wins.
  always_ff @(posedge dest_clk or negedge reset_b) begin
    if (!reset_b) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (flags_clr) r_overflow <= 1'b0;
      if (w_unf_set)      r_underflow <= 1'b1;
      else if (flags_clr) r_underflow <= 1'b0;
    end
  end

  assign spi_miso  = r_miso;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
